// File: rtl/apb_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : apb_bus_master
// Purpose : Bridges the CPU data-bus port onto an APB3 bus with region decode,
//           wait-state timeout and bus-error reporting.
// Revision: 1.0 - initial release
// ============================================================================
module apb_bus_master #(
  parameter int          NUM_SLV     = 4,
  parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
  parameter int          REGION_BITS = 12,
  parameter int          TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  transfer,
  input  logic                  busWe,
  input  logic [31:0]           busAddr,
  input  logic [31:0]           busWData,
  input  logic [3:0]            Byte_Enable,
  output logic [31:0]           busRData,
  output logic                  ready,
  output logic                  error,
  output logic [31:0]           PADDR,
  output logic                  PWRITE,
  output logic [31:0]           PWDATA,
  output logic [3:0]            PSTRB,
  output logic                  PENABLE,
  output logic [NUM_SLV-1:0]    PSEL,
  input  logic [NUM_SLV*32-1:0] PRDATA,
  input  logic [NUM_SLV-1:0]    PREADY,
  input  logic [NUM_SLV-1:0]    PSLVERR
);

  localparam int         c_IDX_W    = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam logic [7:0] c_TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic [31:0]          r_addr;
  logic [31:0]          r_wdata;
  logic [31:0]          r_rdata;
  logic [3:0]           r_strb;
  logic                 r_we;
  logic                 r_err;
  logic [c_IDX_W-1:0]   r_idx;
  logic [7:0]           r_wcnt;

  logic [31:0]          w_off;
  logic                 w_hit;
  logic [c_IDX_W-1:0]   w_idx;
  logic [31:0]          w_sel_rdata;
  logic                 w_sel_ready;
  logic                 w_sel_err;
  logic [NUM_SLV-1:0]   w_onehot;

  // Below-base addresses wrap to huge offsets, so both bounds are tested explicitly
  assign w_off = busAddr - BASE_ADDR;
  assign w_hit = (busAddr >= BASE_ADDR) && ((w_off >> REGION_BITS) < 32'(NUM_SLV));
  assign w_idx = w_off[REGION_BITS +: c_IDX_W];

  always_comb begin
    w_sel_rdata = '0;
    w_sel_ready = 1'b0;
    w_sel_err   = 1'b0;
    w_onehot    = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (r_idx == c_IDX_W'(i)) begin
        w_sel_rdata = PRDATA[32*i +: 32];
        w_sel_ready = PREADY[i];
        w_sel_err   = PSLVERR[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (transfer) w_next = w_hit ? S_SETUP : S_DONE;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (w_sel_ready || (r_wcnt == c_TMO_LAST)) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_strb  <= '0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_idx   <= '0;
      r_wcnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (transfer) begin
            r_addr  <= busAddr;
            r_we    <= busWe;
            r_wdata <= busWData;
            r_strb  <= busWe ? Byte_Enable : 4'b0000;
            r_idx   <= w_idx;
            r_err   <= !w_hit;
            r_wcnt  <= '0;
          end
        end
        S_ACCESS: begin
          r_wcnt <= r_wcnt + 8'd1;
          if (w_sel_ready) begin
            r_err <= w_sel_err;
            if (!r_we) r_rdata <= w_sel_rdata;
          end else if (r_wcnt == c_TMO_LAST) begin
            r_err <= 1'b1;
            if (!r_we) r_rdata <= '0;
          end
        end
        S_DONE:  r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  assign PSEL     = ((r_state == S_SETUP) || (r_state == S_ACCESS)) ? w_onehot : '0;
  assign PENABLE  = (r_state == S_ACCESS);
  assign PADDR    = r_addr;
  assign PWRITE   = r_we;
  assign PWDATA   = r_wdata;
  assign PSTRB    = r_strb;
  assign ready    = (r_state == S_DONE);
  assign error    = r_err;
  assign busRData = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_bus_master.sv
`default_nettype none
// ============================================================================
// Module  : tb_apb_bus_master
// Purpose : Directed scoreboard bench for apb_bus_master with a parametrised
//           wait-state slave model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_apb_bus_master;

  localparam int NSLV = 4;

  logic               clk;
  logic               reset;
  logic               transfer;
  logic               busWe;
  logic [31:0]        busAddr;
  logic [31:0]        busWData;
  logic [3:0]         Byte_Enable;
  logic [31:0]        busRData;
  logic               ready;
  logic               error;
  logic [31:0]        PADDR;
  logic               PWRITE;
  logic [31:0]        PWDATA;
  logic [3:0]         PSTRB;
  logic               PENABLE;
  logic [NSLV-1:0]    PSEL;
  logic [NSLV*32-1:0] PRDATA;
  logic [NSLV-1:0]    PREADY;
  logic [NSLV-1:0]    PSLVERR;

  apb_bus_master #(
    .NUM_SLV    (NSLV),
    .BASE_ADDR  (32'h1000_0000),
    .REGION_BITS(12),
    .TIMEOUT    (4)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .transfer   (transfer),
    .busWe      (busWe),
    .busAddr    (busAddr),
    .busWData   (busWData),
    .Byte_Enable(Byte_Enable),
    .busRData   (busRData),
    .ready      (ready),
    .error      (error),
    .PADDR      (PADDR),
    .PWRITE     (PWRITE),
    .PWDATA     (PWDATA),
    .PSTRB      (PSTRB),
    .PENABLE    (PENABLE),
    .PSEL       (PSEL),
    .PRDATA     (PRDATA),
    .PREADY     (PREADY),
    .PSLVERR    (PSLVERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: unselected slaves drive ready/error high so a wrong-slave
  // observation in the DUT shows up as an early completion or bogus error.
  int acc_cnt = 0;
  int waits   = 0;
  bit stuck   = 1'b0;
  bit slverr  = 1'b0;

  always @(negedge clk) acc_cnt <= (PENABLE && (PSEL != '0)) ? acc_cnt + 1 : 0;

  assign PRDATA  = {32'h3333_3333, 32'h2222_2222, 32'hDEAD_BEEF, 32'hA0A0_0000};
  assign PREADY  = ~PSEL | ((!stuck && PENABLE && (acc_cnt > waits)) ? PSEL : '0);
  assign PSLVERR = ~PSEL | (slverr ? PSEL : '0);

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  typedef struct packed {
    logic [31:0] rd;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   rdy_prev = 0;
  int   rdy_last = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every ready pulse must match the oldest expectation
  always @(negedge clk) begin
    if (ready) begin
      rdy_prev <= rdy_last;
      rdy_last <= cyc;
      if (sb.size() == 0) begin
        chk("unexpected_ready", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_rdata", busRData, e.rd);
        chk("sb_error", {31'd0, error}, {31'd0, e.err});
      end
    end
  end

  task automatic run(input string nm, input bit we, input logic [31:0] addr,
                     input logic [31:0] wd, input logic [3:0] be, input int w,
                     input bit stk, input bit se, input logic [3:0] exp_psel,
                     input logic [31:0] exp_rd, input bit exp_err,
                     input int exp_lat, input bit keep);
    int          lat;
    bit          stable;
    logic [31:0] a0;
    logic [31:0] d0;
    logic [3:0]  s0;
    logic        w0;
    @(posedge clk); #1;
    waits  = w;
    stuck  = stk;
    slverr = se;
    sb.push_back('{rd: exp_rd, err: exp_err});
    busWe = we; busAddr = addr; busWData = wd; Byte_Enable = be; transfer = 1'b1;
    lat = 0; stable = 1'b1;
    a0 = '0; d0 = '0; s0 = '0; w0 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if ($countones(PSEL) > 1) stable = 1'b0;
      if (n == 1) begin
        chk({nm, "_psel_setup"}, {28'd0, PSEL}, {28'd0, exp_psel});
        chk({nm, "_penable_setup"}, {31'd0, PENABLE}, 32'd0);
        if (exp_psel != 4'd0) begin
          chk({nm, "_paddr"}, PADDR, addr);
          chk({nm, "_pwrite"}, {31'd0, PWRITE}, {31'd0, we});
          chk({nm, "_pstrb"}, {28'd0, PSTRB}, {28'd0, (we ? be : 4'b0000)});
          if (we) chk({nm, "_pwdata"}, PWDATA, wd);
        end
        a0 = PADDR; d0 = PWDATA; s0 = PSTRB; w0 = PWRITE;
      end else if (!ready) begin
        if (PSEL !== exp_psel || PENABLE !== 1'b1 || PADDR !== a0 ||
            PWDATA !== d0 || PSTRB !== s0 || PWRITE !== w0) stable = 1'b0;
      end
      if (ready) begin
        lat = n;
        chk({nm, "_done_idle"}, {27'd0, PSEL, PENABLE}, 32'd0);
        break;
      end
    end
    if (!keep || lat == 0) transfer = 1'b0;
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_apb_stable"}, {31'd0, stable}, 32'd1);
  endtask

  initial begin
    reset = 1'b0; transfer = 1'b0; busWe = 1'b0; busAddr = '0;
    busWData = '0; Byte_Enable = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_psel", {28'd0, PSEL}, 32'd0);
    chk("rst_penable", {31'd0, PENABLE}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_rdata", busRData, 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    reset = 1'b1;

    //   name   we  addr           wdata          be       w  stk se psel     rdata          err lat keep
    run("rd0",  0, 32'h1000_1004, 32'h0,         4'b1111, 0, 0, 0, 4'b0010, 32'hDEAD_BEEF, 0,  3,  0);
    run("wr3",  1, 32'h1000_3010, 32'h1234_5678, 4'b0011, 3, 0, 0, 4'b1000, 32'hDEAD_BEEF, 0,  6,  0);
    run("miss", 0, 32'h2000_0000, 32'h0,         4'b0000, 0, 0, 0, 4'b0000, 32'hDEAD_BEEF, 1,  1,  0);
    run("mlo",  0, 32'h0FFF_FFFC, 32'h0,         4'b0000, 0, 0, 0, 4'b0000, 32'hDEAD_BEEF, 1,  1,  0);
    run("mhi",  1, 32'h1000_4000, 32'h55,        4'b1111, 0, 0, 0, 4'b0000, 32'hDEAD_BEEF, 1,  1,  0);
    run("top",  0, 32'h1000_3FFC, 32'h0,         4'b0000, 1, 0, 0, 4'b1000, 32'h3333_3333, 0,  4,  0);
    run("serr", 0, 32'h1000_0000, 32'h0,         4'b0000, 0, 0, 1, 4'b0001, 32'hA0A0_0000, 1,  3,  0);
    run("wtmo", 1, 32'h1000_1000, 32'h9999_0000, 4'b1000, 0, 1, 0, 4'b0010, 32'hA0A0_0000, 1,  6,  0);
    run("rtmo", 0, 32'h1000_2000, 32'h0,         4'b0000, 0, 1, 0, 4'b0100, 32'h0000_0000, 1,  6,  0);
    run("rd1",  0, 32'h1000_1000, 32'h0,         4'b0000, 2, 0, 0, 4'b0010, 32'hDEAD_BEEF, 0,  5,  0);

    // Reset in the middle of ACCESS: outputs must clear before the next edge
    @(posedge clk); #1;
    stuck = 1'b1; busWe = 1'b0; busAddr = 32'h1000_1008; transfer = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_access", {31'd0, PENABLE}, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_psel", {28'd0, PSEL}, 32'd0);
    chk("arst_penable", {31'd0, PENABLE}, 32'd0);
    chk("arst_ready", {31'd0, ready}, 32'd0);
    chk("arst_rdata", busRData, 32'd0);
    transfer = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    stuck = 1'b0;

    run("post", 0, 32'h1000_1004, 32'h0,         4'b0000, 0, 0, 0, 4'b0010, 32'hDEAD_BEEF, 0,  3,  0);
    run("b2b2", 0, 32'h1000_2000, 32'h0,         4'b0000, 0, 0, 0, 4'b0100, 32'h2222_2222, 0,  3,  1);
    run("b2b3", 0, 32'h1000_3000, 32'h0,         4'b0000, 0, 0, 0, 4'b1000, 32'h3333_3333, 0,  3,  0);

    repeat (3) @(posedge clk);
    #1;
    chk("b2b_spacing", 32'(rdy_last - rdy_prev), 32'd4);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
